e203_nts_ctx_ctrl: RTL and testbench
====================================

Name: e203_nts_ctx_ctrl

Overview:
- Initiator/controller for the NTS (nested trap save) context RAM port.
- On an interrupt-entry request it streams core register contents into the NTS RAM as one stack frame.
- On mret it reads the newest frame back and writes it into the register file.
- Sits between the trap/commit logic and the DTCM NTS port (cs_nts/we_nts/addr_nts/wem_nts/din_nts/dout_nts); it replaces ad-hoc save/restore sequencing.

Parameters:
- NREG, 15: registers per frame (x1..x15, RV32E); must be <= 2**FRAME_AW.
- FRAME_AW, 4: log2 of frame stride in words.
- DEPTH_AW, 2: log2 of max nesting depth (NDEPTH = 4 frames).
- DW, 32: data width; equals NTS RAM DW.
- MW, 4: write-mask width; equals NTS RAM MW.
- AW, DEPTH_AW+FRAME_AW: NTS RAM address width.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- irq_save_i  in  1  single-cycle pulse: save a frame.
- mret_i  in  1  single-cycle pulse: restore newest frame.
- rf_rd_idx  out  5  register-file read index (combinational read).
- rf_rd_data  in  DW  register-file read data for rf_rd_idx, same cycle.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_idx  out  5  register-file write index.
- rf_wr_data  out  DW  register-file write data.
- cs_nts  out  1  NTS RAM chip select.
- we_nts  out  1  NTS RAM write enable.
- addr_nts  out  AW  NTS RAM word address.
- wem_nts  out  MW  NTS RAM write mask.
- din_nts  out  DW  NTS RAM write data.
- dout_nts  in  DW  NTS RAM read data, valid 1 cycle after a read select.
- busy  out  1  high while in SAVE/RESTORE/DRAIN.
- save_done  out  1  1-cycle pulse after the last save write.
- restore_done  out  1  1-cycle pulse after the last register-file write.
- ovf_err  out  1  1-cycle pulse: save refused because depth == NDEPTH.
- udf_err  out  1  1-cycle pulse: restore refused because depth == 0.
- depth  out  DEPTH_AW+1  current number of saved frames.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs 0; depth=0; FSM=IDLE; pending flags cleared. Applies mid-operation too: cs_nts=0 from the next cycle, partial frame discarded, depth not incremented.
- FSM states: IDLE, SAVE, RESTORE, DRAIN.
- Pending flags: irq_save_i and mret_i set pend_save/pend_rst in any state. A flag clears when its request is accepted or rejected. A second pulse while a flag is already set is merged.
- IDLE arbitration: pend_save has priority over pend_rst. Acceptance is evaluated in the cycle after the pulse; the first RAM access occurs in that cycle.
- Save rejection: save with depth==NDEPTH -> ovf_err pulse, no RAM access, stay IDLE.
- Restore rejection: restore with depth==0 -> udf_err pulse, stay IDLE.
- SAVE (counter i = 0..NREG-1, one word per cycle):
  - rf_rd_idx = i+1; cs_nts=1; we_nts=1; wem_nts=all ones; din_nts=rf_rd_data.
  - addr_nts = {depth[DEPTH_AW-1:0], i[FRAME_AW-1:0]}.
  - After i=NREG-1: depth+1, save_done pulse in the following cycle (IDLE).
  - Total latency: NREG cycles of access; save_done at cycle NREG+1 after acceptance.
- RESTORE (counter i = 0..NREG-1):
  - cs_nts=1; we_nts=0; wem_nts=0; addr_nts = {depth-1, i}.
  - One cycle later: rf_wr_en=1, rf_wr_idx=i+1, rf_wr_data=dout_nts.
  - After the last read, go to DRAIN (one cycle, final rf write). Then depth-1, restore_done pulse, return to IDLE.
- Bus idle values: when not accessing, cs_nts=we_nts=0; din_nts and addr_nts hold 0.
- busy = (FSM != IDLE). Pending requests are serviced back-to-back with no idle gap beyond the 1-cycle arbitration.
- depth never wraps; it saturates only via the ovf/udf rejections.

Test Plan:
- Single save: rf[x]=0x1000+x, pulse irq_save_i -> 15 writes, addr 0..14, din 0x1001..0x100F, wem=0xF, save_done at cycle 16, depth=1.
- Restore after save: clobber rf with 0, pulse mret_i -> reads addr 0..14, rf writes x1..x15 = 0x1001..0x100F, restore_done, depth=0.
- Nesting: two saves (2nd with rf=0x2000+x), then mret -> reads addr 16..30, restores 0x2001..; second mret -> addr 0..14, depth=0.
- Overflow/underflow: mret at depth 0 -> udf_err=1 one cycle, cs_nts never high. Five saves -> 5th gives ovf_err, depth stays 4.
- Simultaneous irq_save_i+mret_i at depth 1 -> save frame 1 completes (depth 2), then restore reads addr 16..30, final depth 1.
- Reset at SAVE cycle 5 -> next cycle cs_nts=0, busy=0, depth=0. A new save then writes starting at addr 0.

Source files
------------

// File: rtl/e203_nts_ctx_ctrl.sv
// ---------------------------------------------------------------------------
// e203_nts_ctx_ctrl
//
// Controller for the NTS (nested trap save) context RAM port. On an
// interrupt-entry request it copies x1..x(NREG) from the register file into
// the NTS RAM as one stack frame. On mret it reads the newest frame back and
// writes it into the register file. Frames are stacked: frame f occupies
// words {f, 0..NREG-1}, so the frame stride is 2**FRAME_AW words.
//
// Ports
//   clk, rst      : core clock, synchronous active-high reset
//   irq_save_i    : 1-cycle pulse, push a frame
//   mret_i        : 1-cycle pulse, pop the newest frame
//   rf_rd_idx     : register-file read index (combinational read port)
//   rf_rd_data    : register-file read data for rf_rd_idx, same cycle
//   rf_wr_en/idx/data : register-file write port
//   cs_nts, we_nts, addr_nts, wem_nts, din_nts : NTS RAM request side
//   dout_nts      : NTS RAM read data, one cycle after a read select
//   busy          : FSM is in SAVE, RESTORE or DRAIN
//   save_done     : pulse in the cycle after the last save write
//   restore_done  : pulse in the cycle after the last register-file write
//   ovf_err       : pulse, save refused because the stack is full
//   udf_err       : pulse, restore refused because the stack is empty
//   depth         : number of frames currently saved
// ---------------------------------------------------------------------------
module e203_nts_ctx_ctrl #(
  parameter int NREG     = 15,
  parameter int FRAME_AW = 4,
  parameter int DEPTH_AW = 2,
  parameter int DW       = 32,
  parameter int MW       = 4,
  parameter int AW       = DEPTH_AW + FRAME_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                irq_save_i,
  input  logic                mret_i,
  output logic [4:0]          rf_rd_idx,
  input  logic [DW-1:0]       rf_rd_data,
  output logic                rf_wr_en,
  output logic [4:0]          rf_wr_idx,
  output logic [DW-1:0]       rf_wr_data,
  output logic                cs_nts,
  output logic                we_nts,
  output logic [AW-1:0]       addr_nts,
  output logic [MW-1:0]       wem_nts,
  output logic [DW-1:0]       din_nts,
  input  logic [DW-1:0]       dout_nts,
  output logic                busy,
  output logic                save_done,
  output logic                restore_done,
  output logic                ovf_err,
  output logic                udf_err,
  output logic [DEPTH_AW:0]   depth
);

  localparam int                NDEPTH    = 2 ** DEPTH_AW;
  localparam logic [DEPTH_AW:0] DEPTH_MAX = NDEPTH[DEPTH_AW:0];
  localparam logic [FRAME_AW-1:0] CNT_LAST = FRAME_AW'(NREG - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t              state_r, state_nxt;
  logic [FRAME_AW-1:0] cnt_r, cnt_nxt;
  logic [DEPTH_AW:0]   depth_r, depth_nxt;
  logic                pend_save_r, pend_save_nxt;
  logic                pend_rst_r, pend_rst_nxt;
  logic                save_done_r, save_done_nxt;
  logic                restore_done_r, restore_done_nxt;
  logic                ovf_r, ovf_nxt;
  logic                udf_r, udf_nxt;
  logic                rf_wr_en_r, rf_wr_en_nxt;
  logic [4:0]          rf_wr_idx_r, rf_wr_idx_nxt;

  // Requests visible this cycle: a fresh pulse is folded in so that a pulse
  // is accepted at the very next edge and the first RAM access lands in the
  // cycle right after the pulse.
  logic req_save_s;
  logic req_rst_s;
  logic take_save_s;
  logic take_rst_s;
  // Frame index of the newest saved frame (depth-1, truncated to the frame field)
  logic [DEPTH_AW-1:0] rd_frame_s;

  assign req_save_s = pend_save_r | irq_save_i;
  assign req_rst_s  = pend_rst_r  | mret_i;
  assign rd_frame_s = depth_r[DEPTH_AW-1:0] - {{(DEPTH_AW-1){1'b0}}, 1'b1};

  // Next-state, counter, depth and status-pulse logic.
  always_comb begin
    state_nxt        = state_r;
    cnt_nxt          = cnt_r;
    depth_nxt        = depth_r;
    save_done_nxt    = 1'b0;
    restore_done_nxt = 1'b0;
    ovf_nxt          = 1'b0;
    udf_nxt          = 1'b0;
    rf_wr_en_nxt     = 1'b0;
    rf_wr_idx_nxt    = 5'd0;
    take_save_s      = 1'b0;
    take_rst_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Save wins over restore; a refused request is consumed too.
        if (req_save_s) begin
          take_save_s = 1'b1;
          if (depth_r == DEPTH_MAX) begin
            ovf_nxt = 1'b1;
          end else begin
            state_nxt = ST_SAVE;
            cnt_nxt   = {FRAME_AW{1'b0}};
          end
        end else if (req_rst_s) begin
          take_rst_s = 1'b1;
          if (depth_r == {(DEPTH_AW+1){1'b0}}) begin
            udf_nxt = 1'b1;
          end else begin
            state_nxt = ST_RESTORE;
            cnt_nxt   = {FRAME_AW{1'b0}};
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_SAVE: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt     = ST_IDLE;
          cnt_nxt       = {FRAME_AW{1'b0}};
          depth_nxt     = depth_r + {{DEPTH_AW{1'b0}}, 1'b1};
          save_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_r + {{(FRAME_AW-1){1'b0}}, 1'b1};
        end
      end

      ST_RESTORE: begin
        // The word read now returns next cycle; schedule its rf write then.
        rf_wr_en_nxt  = 1'b1;
        rf_wr_idx_nxt = 5'(cnt_r) + 5'd1;
        if (cnt_r == CNT_LAST) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = {FRAME_AW{1'b0}};
        end else begin
          cnt_nxt = cnt_r + {{(FRAME_AW-1){1'b0}}, 1'b1};
        end
      end

      ST_DRAIN: begin
        // Last rf write happens this cycle; the frame is released afterwards.
        state_nxt        = ST_IDLE;
        depth_nxt        = depth_r - {{DEPTH_AW{1'b0}}, 1'b1};
        restore_done_nxt = 1'b1;
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = {FRAME_AW{1'b0}};
      end
    endcase

    // Pending flags capture pulses in any state and merge repeats.
    pend_save_nxt = req_save_s & ~take_save_s;
    pend_rst_nxt  = req_rst_s  & ~take_rst_s;
  end

  // State, counters, pending flags and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {FRAME_AW{1'b0}};
      depth_r        <= {(DEPTH_AW+1){1'b0}};
      pend_save_r    <= 1'b0;
      pend_rst_r     <= 1'b0;
      save_done_r    <= 1'b0;
      restore_done_r <= 1'b0;
      ovf_r          <= 1'b0;
      udf_r          <= 1'b0;
      rf_wr_en_r     <= 1'b0;
      rf_wr_idx_r    <= 5'd0;
    end else begin
      state_r        <= state_nxt;
      cnt_r          <= cnt_nxt;
      depth_r        <= depth_nxt;
      pend_save_r    <= pend_save_nxt;
      pend_rst_r     <= pend_rst_nxt;
      save_done_r    <= save_done_nxt;
      restore_done_r <= restore_done_nxt;
      ovf_r          <= ovf_nxt;
      udf_r          <= udf_nxt;
      rf_wr_en_r     <= rf_wr_en_nxt;
      rf_wr_idx_r    <= rf_wr_idx_nxt;
    end
  end

  // NTS RAM request and rf read index, decoded from registered state only
  // (din_nts follows the combinational rf read during SAVE).
  always_comb begin
    cs_nts    = 1'b0;
    we_nts    = 1'b0;
    wem_nts   = {MW{1'b0}};
    addr_nts  = {AW{1'b0}};
    din_nts   = {DW{1'b0}};
    rf_rd_idx = 5'd0;
    case (state_r)
      ST_SAVE: begin
        cs_nts    = 1'b1;
        we_nts    = 1'b1;
        wem_nts   = {MW{1'b1}};
        addr_nts  = {depth_r[DEPTH_AW-1:0], cnt_r};
        rf_rd_idx = 5'(cnt_r) + 5'd1;
        din_nts   = rf_rd_data;
      end
      ST_RESTORE: begin
        cs_nts   = 1'b1;
        addr_nts = {rd_frame_s, cnt_r};
      end
      default: begin
        cs_nts = 1'b0;
      end
    endcase
  end

  // Register-file write data comes straight from the RAM read port.
  always_comb begin
    if (rf_wr_en_r) begin
      rf_wr_data = dout_nts;
    end else begin
      rf_wr_data = {DW{1'b0}};
    end
  end

  assign rf_wr_en     = rf_wr_en_r;
  assign rf_wr_idx    = rf_wr_idx_r;
  assign busy         = (state_r != ST_IDLE);
  assign save_done    = save_done_r;
  assign restore_done = restore_done_r;
  assign ovf_err      = ovf_r;
  assign udf_err      = udf_r;
  assign depth        = depth_r;

endmodule

// File: tb/tb_e203_nts_ctx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e203_nts_ctx_ctrl
//
// Self-checking bench for e203_nts_ctx_ctrl. The bench provides a register
// file and an NTS RAM, keeps a reference stack of saved frames, and checks the
// cycle-by-cycle RAM traffic, rf write-back and status pulses. A directed
// table covers the main scenarios, hand sequences cover back-to-back and
// mid-operation reset, and a random phase exercises mixed push/pop traffic.
// ---------------------------------------------------------------------------
module tb_e203_nts_ctx_ctrl;

  logic        clk;
  logic        rst;
  logic        irq_save_i;
  logic        mret_i;
  logic [4:0]  rf_rd_idx;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_idx;
  logic [31:0] rf_wr_data;
  logic        cs_nts;
  logic        we_nts;
  logic [5:0]  addr_nts;
  logic [3:0]  wem_nts;
  logic [31:0] din_nts;
  logic [31:0] dout_nts;
  logic        busy;
  logic        save_done;
  logic        restore_done;
  logic        ovf_err;
  logic        udf_err;
  logic [2:0]  depth;

  e203_nts_ctx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq_save_i   (irq_save_i),
    .mret_i       (mret_i),
    .rf_rd_idx    (rf_rd_idx),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_idx    (rf_wr_idx),
    .rf_wr_data   (rf_wr_data),
    .cs_nts       (cs_nts),
    .we_nts       (we_nts),
    .addr_nts     (addr_nts),
    .wem_nts      (wem_nts),
    .din_nts      (din_nts),
    .dout_nts     (dout_nts),
    .busy         (busy),
    .save_done    (save_done),
    .restore_done (restore_done),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err),
    .depth        (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: register file and NTS RAM
  logic [31:0] rf   [0:31];
  logic [31:0] seed [0:15];
  logic        rf_load;
  logic [31:0] mem  [0:63];
  logic [31:0] dout_r;

  assign rf_rd_data = rf[rf_rd_idx];
  assign dout_nts   = dout_r;

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 1; i < 16; i++) rf[i] <= seed[i];
    end else if (rf_wr_en) begin
      rf[rf_wr_idx] <= rf_wr_data;
    end
  end

  always @(posedge clk) begin
    if (cs_nts && we_nts) mem[addr_nts] <= din_nts;
    if (cs_nts && !we_nts) dout_r <= mem[addr_nts];
  end

  // Reference model: a stack of register snapshots
  logic [31:0] mstk [0:3][0:15];
  int          mdepth;

  int n_chk;
  int n_err;
  bit last_err;

  typedef struct {
    bit          is_rst;
    logic [31:0] base;
    int          exp_depth;
    bit          exp_err;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic b, input logic c, input logic w,
                                       input logic [3:0] m, input logic [5:0] a,
                                       input logic [31:0] d);
    return {19'd0, b, c, w, m, a, d};
  endfunction

  function automatic logic [63:0] bus_now();
    return pack(busy, cs_nts, we_nts, wem_nts, addr_nts, din_nts);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rf();
    rf_load = 1'b1;
    step();
    rf_load = 1'b0;
  endtask

  task automatic load_base(input logic [31:0] base);
    for (int x = 0; x < 16; x++) seed[x] = base + 32'(x);
    load_rf();
  endtask

  task automatic load_rand();
    for (int x = 0; x < 16; x++) seed[x] = $urandom;
    load_rf();
  endtask

  // Pulse the request inputs for one cycle; returns in the first cycle after.
  task automatic pulse(input bit s, input bit r);
    irq_save_i = s;
    mret_i     = r;
    step();
    irq_save_i = 1'b0;
    mret_i     = 1'b0;
    last_err   = ovf_err | udf_err;
  endtask

  // Called in the first cycle after the request; ends in the save_done cycle
  // (or one cycle after the ovf pulse when refused).
  task automatic expect_save(input int d0);
    if (d0 >= 4) begin
      chk("ovf_pulse", {61'd0, ovf_err, cs_nts, save_done}, 64'b100);
      step();
      chk("ovf_clear", {60'd0, ovf_err, depth}, {60'd0, 1'b0, 3'd4});
    end else begin
      for (int k = 0; k < 15; k++) begin
        chk($sformatf("save_bus_f%0d_w%0d", d0, k), bus_now(),
            pack(1'b1, 1'b1, 1'b1, 4'hF, 6'(d0 * 16 + k), seed[k+1]));
        step();
      end
      chk("save_done", {58'd0, save_done, busy, cs_nts, depth},
          {58'd0, 1'b1, 1'b0, 1'b0, 3'(d0 + 1)});
      for (int x = 0; x < 16; x++) mstk[d0][x] = seed[x];
      mdepth = d0 + 1;
    end
  endtask

  // Called in the first cycle after acceptance; ends in the restore_done
  // cycle (or one cycle after the udf pulse when refused).
  task automatic expect_restore(input int d0);
    if (d0 == 0) begin
      chk("udf_pulse", {61'd0, udf_err, cs_nts, busy}, 64'b100);
      step();
      chk("udf_clear", {59'd0, udf_err, cs_nts, depth}, 64'd0);
    end else begin
      for (int k = 0; k < 15; k++) begin
        chk($sformatf("rst_bus_f%0d_w%0d", d0 - 1, k), bus_now(),
            pack(1'b1, 1'b1, 1'b0, 4'h0, 6'((d0 - 1) * 16 + k), 32'h0));
        if (k == 0) chk("rst_wr_first", {63'd0, rf_wr_en}, 64'd0);
        else chk($sformatf("rst_wr_x%0d", k), {26'd0, rf_wr_en, rf_wr_idx, rf_wr_data},
                 {26'd0, 1'b1, 5'(k), mstk[d0-1][k]});
        step();
      end
      chk("drain", {25'd0, busy, cs_nts, rf_wr_en, rf_wr_idx, rf_wr_data},
          {25'd0, 1'b1, 1'b0, 1'b1, 5'd15, mstk[d0-1][15]});
      step();
      chk("restore_done", {59'd0, restore_done, busy, depth},
          {59'd0, 1'b1, 1'b0, 3'(d0 - 1)});
      for (int x = 1; x < 16; x++)
        chk($sformatf("rf_x%0d", x), {32'd0, rf[x]}, {32'd0, mstk[d0-1][x]});
      mdepth = d0 - 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int d;
    int r;
    n_chk = 0; n_err = 0; mdepth = 0; last_err = 1'b0;
    rst = 1'b1; irq_save_i = 1'b0; mret_i = 1'b0; rf_load = 1'b0;
    dout_r = 32'h0;
    for (int x = 0; x < 16; x++) seed[x] = 32'h0;
    for (int x = 0; x < 32; x++) rf[x] = 32'h0;

    //            is_rst base          depth err exp_base
    vt[0]  = '{1'b0, 32'h1000, 1, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 32'h0,    0, 1'b0, 32'h1000};
    vt[2]  = '{1'b0, 32'h1000, 1, 1'b0, 32'h0};
    vt[3]  = '{1'b0, 32'h2000, 2, 1'b0, 32'h0};
    vt[4]  = '{1'b1, 32'h0,    1, 1'b0, 32'h2000};
    vt[5]  = '{1'b1, 32'h0,    0, 1'b0, 32'h1000};
    vt[6]  = '{1'b1, 32'h0,    0, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 32'h3000, 1, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 32'h4000, 2, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h5000, 3, 1'b0, 32'h0};
    vt[10] = '{1'b0, 32'h6000, 4, 1'b0, 32'h0};
    vt[11] = '{1'b0, 32'h7000, 4, 1'b1, 32'h0};
    vt[12] = '{1'b1, 32'h0,    3, 1'b0, 32'h6000};
    vt[13] = '{1'b1, 32'h0,    2, 1'b0, 32'h5000};
    vt[14] = '{1'b1, 32'h0,    1, 1'b0, 32'h4000};

    // Reset state
    step(); step(); step();
    chk("reset_outputs",
        {cs_nts, we_nts, wem_nts, addr_nts, din_nts, busy, save_done, restore_done,
         ovf_err, udf_err, depth, rf_wr_en, rf_wr_idx},
        64'd0);
    rst = 1'b0;
    step();

    // Directed table
    for (int i = 0; i < 15; i++) begin
      load_base(vt[i].base);
      pulse(!vt[i].is_rst, vt[i].is_rst);
      if (vt[i].is_rst) expect_restore(mdepth);
      else expect_save(mdepth);
      chk($sformatf("tbl%0d_depth", i), {61'd0, depth}, 64'(vt[i].exp_depth));
      chk($sformatf("tbl%0d_err", i), {63'd0, last_err}, {63'd0, vt[i].exp_err});
      if (vt[i].exp_base != 32'h0)
        for (int x = 1; x < 16; x++)
          chk($sformatf("tbl%0d_rf_x%0d", i, x), {32'd0, rf[x]}, {32'd0, vt[i].exp_base + 32'(x)});
      step();
    end

    // Simultaneous save + mret at depth 1: save frame 1, then restore it
    load_base(32'hA000);
    pulse(1'b1, 1'b1);
    expect_save(1);
    step();
    expect_restore(2);
    chk("simul_depth", {61'd0, depth}, 64'd1);
    for (int x = 1; x < 16; x++)
      chk($sformatf("simul_rf_x%0d", x), {32'd0, rf[x]}, {32'd0, 32'hA000 + 32'(x)});
    step();

    // Reset in the fifth save cycle
    load_base(32'hB000);
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("prerst_bus_w%0d", k), bus_now(),
          pack(1'b1, 1'b1, 1'b1, 4'hF, 6'(16 + k), seed[k+1]));
      if (k < 4) step();
    end
    rst = 1'b1;
    step();
    chk("midrst", {59'd0, cs_nts, busy, depth, save_done}, 64'd0);
    rst = 1'b0;
    mdepth = 0;
    step();
    load_base(32'hC000);
    pulse(1'b1, 1'b0);
    expect_save(0);
    step();

    // Random mixed traffic against the reference stack
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        load_rand();
        pulse(1'b1, 1'b0);
        expect_save(mdepth);
      end else if (r < 8) begin
        load_rand();
        pulse(1'b0, 1'b1);
        expect_restore(mdepth);
      end else begin
        load_rand();
        pulse(1'b1, 1'b1);
        d = mdepth;
        expect_save(d);
        if (d < 4) step();
        expect_restore(mdepth);
      end
      step();
      chk($sformatf("rand%0d_depth", n), {61'd0, depth}, 64'(mdepth));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
